program_run_controller: RTL and testbench

- Sequencer that sits directly upstream of the single-core SoC top.
- Drives the SoC's reset, start and program_address inputs, and snoops the core's data-memory write port for a write to a "tohost" mailbox address.
- Reports pass/fail/timeout and the run cycle count to a bench or host controller.
- Also generates the SoC scan request window, under the optional feature below.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/run_cycle_counter.sv | 42 ++++
 rtl/program_run_controller.sv | 208 ++++++++++++++++++++
 tb/tb_program_run_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the program run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHoldReset,
    StStart,
    StRun,
    StDone
  } run_state_e;

  // Mailbox value that signals a passing program.
  localparam int unsigned PASS_CODE = 1;

  // A run ends only on a full-word write to the mailbox address.
  function automatic logic mailbox_hit(input logic write, input logic addr_match,
                                       input logic full_word);
    return write & addr_match & full_word;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter with clear, load and enable.
// COUNT_DOWN selects down-counting (saturates at zero) or up-counting (saturates at all ones).
module run_cycle_counter #(
  parameter int unsigned COUNT_BITS = 32,
  parameter bit          COUNT_DOWN = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [COUNT_BITS-1:0] load_value,
  input  logic                  enable,
  output logic [COUNT_BITS-1:0] count
);

  logic [COUNT_BITS-1:0] count_d, count_q;

  // Next count: clear beats load beats enable; the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      if (COUNT_DOWN) begin
        if (count_q != '0) count_d = count_q - COUNT_BITS'(1);
      end else begin
        if (count_q != '1) count_d = count_q + COUNT_BITS'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/program_run_controller.sv
// Program run controller: resets and starts the SoC, snoops the tohost mailbox and reports
// pass/fail/timeout plus the run cycle count.
// Optional macro RUN_SCAN_WINDOW_EN: drive scan high while cycle_count is inside
// [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX] during RUN; otherwise scan is tied low.
module program_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH      = 32,
  parameter int unsigned                ADDRESS_BITS    = 32,
  parameter logic [ADDRESS_BITS-1:0]    TOHOST_ADDRESS  = ADDRESS_BITS'(32'h0000_0FF0),
  parameter int unsigned                RESET_CYCLES    = 4,
  parameter int unsigned                TIMEOUT_CYCLES  = 100000,
  parameter int unsigned                COUNT_BITS      = 32,
  parameter int unsigned                SCAN_CYCLES_MIN = 0,
  parameter int unsigned                SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    launch,
  input  logic [ADDRESS_BITS-1:0] launch_address,
  input  logic                    abort,
  input  logic                    ack,
  input  logic                    mem_write,
  input  logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic [ADDRESS_BITS-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [ADDRESS_BITS-1:0] core_program_address,
  output logic                    scan,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timed_out,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [COUNT_BITS-1:0]   cycle_count
);

  // A counter too narrow for the timeout saturates, so the limit is clamped to all ones.
  localparam longint unsigned CountMax =
      (COUNT_BITS >= 64) ? '1 : ((64'd1 << COUNT_BITS) - 64'd1);
  localparam longint unsigned TimeoutLast = 64'(TIMEOUT_CYCLES) - 64'd1;
  localparam logic [COUNT_BITS-1:0] TimeoutLimit =
      COUNT_BITS'((TimeoutLast > CountMax) ? CountMax : TimeoutLast);
  localparam logic [COUNT_BITS-1:0] ResetLoad = COUNT_BITS'(RESET_CYCLES - 1);

  run_state_e state_d, state_q;

  logic [ADDRESS_BITS-1:0] prog_addr_d, prog_addr_q;
  logic [DATA_WIDTH-1:0]   result_d, result_q;
  logic                    pass_d, pass_q;
  logic                    timed_out_d, timed_out_q;

  logic                  rst_load, rst_en;
  logic                  run_clear, run_en;
  logic [COUNT_BITS-1:0] rst_count;
  logic                  hit;
  logic                  timeout_hit;

  assign hit = mailbox_hit(mem_write, (mem_address == TOHOST_ADDRESS), &mem_byte_en);
  assign timeout_hit = (cycle_count == TimeoutLimit);

  // Down-counts the remaining HOLD_RESET cycles.
  run_cycle_counter #(
    .COUNT_BITS(COUNT_BITS),
    .COUNT_DOWN(1'b1)
  ) u_reset_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .load      (rst_load),
    .load_value(ResetLoad),
    .enable    (rst_en),
    .count     (rst_count)
  );

  // Up-counts RUN cycles; this is the reported cycle_count.
  run_cycle_counter #(
    .COUNT_BITS(COUNT_BITS),
    .COUNT_DOWN(1'b0)
  ) u_run_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (run_clear),
    .load      (1'b0),
    .load_value('0),
    .enable    (run_en),
    .count     (cycle_count)
  );

  // Next-state and result update; abort outranks a mailbox hit, a hit outranks timeout.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    result_d    = result_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    rst_load    = 1'b0;
    rst_en      = 1'b0;
    run_clear   = 1'b0;
    run_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) begin
          prog_addr_d = launch_address;
          result_d    = '0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          rst_load    = 1'b1;
          state_d     = StHoldReset;
        end
      end
      StHoldReset: begin
        if (abort)                 state_d = StIdle;
        else if (rst_count == '0)  state_d = StStart;
        else                       rst_en  = 1'b1;
      end
      StStart: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          run_clear = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (hit) begin
          result_d    = mem_data;
          pass_d      = (mem_data == DATA_WIDTH'(PASS_CODE));
          timed_out_d = 1'b0;
          state_d     = StDone;
        end else if (timeout_hit) begin
          pass_d      = 1'b0;
          timed_out_d = 1'b1;
          state_d     = StDone;
        end else begin
          run_en = 1'b1;
        end
      end
      StDone: begin
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      prog_addr_q <= '0;
      result_q    <= '0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      result_q    <= result_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Core control and status decoded from the current state.
  always_comb begin
    core_reset = !((state_q == StStart) || (state_q == StRun));
    core_start = (state_q == StStart);
    busy       = (state_q == StHoldReset) || (state_q == StStart) || (state_q == StRun);
    done       = (state_q == StDone);
  end

  assign core_program_address = prog_addr_q;
  assign result               = result_q;
  assign pass                 = pass_q;
  assign timed_out            = timed_out_q;

`ifdef RUN_SCAN_WINDOW_EN
  localparam logic [COUNT_BITS-1:0] ScanMin  = COUNT_BITS'(SCAN_CYCLES_MIN);
  localparam logic [COUNT_BITS-1:0] ScanSpan = COUNT_BITS'(SCAN_CYCLES_MAX - SCAN_CYCLES_MIN);

  logic [COUNT_BITS-1:0] count_next;
  logic                  scan_d, scan_q;

  // Predict next cycle_count so the registered scan lines up with it; the offset compare
  // covers MIN..MAX inclusive without a compare against zero.
  always_comb begin
    count_next = cycle_count;
    if (run_clear)                          count_next = '0;
    else if (run_en && cycle_count != '1)   count_next = cycle_count + COUNT_BITS'(1);
    scan_d = (state_d == StRun) && ((count_next - ScanMin) <= ScanSpan);
  end

  // Scan request register.
  always_ff @(posedge clock) begin
    if (reset) scan_q <= 1'b0;
    else       scan_q <= scan_d;
  end

  assign scan = scan_q;
`else
  logic unused_scan_params;
  assign unused_scan_params = ^{32'(SCAN_CYCLES_MIN), 32'(SCAN_CYCLES_MAX)};
  assign scan = 1'b0;
`endif

endmodule

// File: tb/tb_program_run_controller.sv
// Self-checking bench for program_run_controller: a default instance plus a short-timeout
// instance share all stimulus.
module tb_program_run_controller;

  localparam logic [31:0] Tohost = 32'h0000_0FF0;
`ifdef RUN_SCAN_WINDOW_EN
  localparam bit ScanEn = 1'b1;
`else
  localparam bit ScanEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, launch, abort, ack, mem_write;
  logic [31:0] launch_address, mem_address, mem_data;
  logic [3:0]  mem_byte_en;

  logic        core_reset, core_start, scan, busy, done, pass, timed_out;
  logic [31:0] core_program_address, result, cycle_count;
  logic        t_core_reset, t_core_start, t_scan, t_busy, t_done, t_pass, t_timed_out;
  logic [31:0] t_core_program_address, t_result, t_cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  program_run_controller #(
    .SCAN_CYCLES_MIN(3),
    .SCAN_CYCLES_MAX(5)
  ) dut (
    .clock(clock), .reset(reset), .launch(launch), .launch_address(launch_address),
    .abort(abort), .ack(ack), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_address(mem_address), .mem_data(mem_data), .core_reset(core_reset),
    .core_start(core_start), .core_program_address(core_program_address), .scan(scan),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out), .result(result),
    .cycle_count(cycle_count)
  );

  program_run_controller #(
    .TIMEOUT_CYCLES (20),
    .SCAN_CYCLES_MIN(3),
    .SCAN_CYCLES_MAX(5)
  ) dut_t (
    .clock(clock), .reset(reset), .launch(launch), .launch_address(launch_address),
    .abort(abort), .ack(ack), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_address(mem_address), .mem_data(mem_data), .core_reset(t_core_reset),
    .core_start(t_core_start), .core_program_address(t_core_program_address),
    .scan(t_scan), .busy(t_busy), .done(t_done), .pass(t_pass), .timed_out(t_timed_out),
    .result(t_result), .cycle_count(t_cycle_count)
  );

  typedef struct {
    logic [31:0] addr;
    int          hit_cyc;
    logic [31:0] data;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Launch and advance to RUN cycle 0.
  task automatic launch_run(input logic [31:0] addr);
    bit seen = 1'b0;
    launch = 1'b1;
    launch_address = addr;
    tick();
    launch = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (core_start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("start_seen", 64'(seen), 64'd1);
    tick();
  endtask

  // Starting in RUN cycle 0, write the mailbox on relative cycle hit_cyc (<0: never) and wait
  // for done on the selected instance.
  task automatic run_until_done(input bit sel, input int hit_cyc, input logic [31:0] data,
                                input logic [3:0] be, input int limit, input bit chk_scan,
                                output bit got, output int at);
    int scan_bad = 0;
    got = 1'b0;
    at  = -1;
    for (int c = 0; c < limit; c++) begin
      if (chk_scan && scan !== (ScanEn && c >= 3 && c <= 5)) scan_bad++;
      if (c == hit_cyc) begin
        mem_write   = 1'b1;
        mem_address = Tohost;
        mem_byte_en = be;
        mem_data    = data;
      end
      tick();
      mem_write = 1'b0;
      if ((sel ? t_done : done) === 1'b1) begin
        got = 1'b1;
        at  = c;
        break;
      end
    end
    if (chk_scan) begin
      if (scan !== 1'b0) scan_bad++;
      check("scan_window", 64'(scan_bad), 64'd0);
    end
  endtask

  initial begin
    bit got;
    int at;

    vecs[0] = '{32'h0000_0100, 50, 32'h0000_0001, 1'b1};
    vecs[1] = '{32'h0000_0200, 10, 32'h0000_0007, 1'b0};
    vecs[2] = '{32'h0000_0300, 0,  32'h0000_0001, 1'b1};
    vecs[3] = '{32'h0000_0400, 3,  32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_0500, 7,  32'h0000_0101, 1'b0};

    reset = 1'b1; launch = 1'b0; abort = 1'b0; ack = 1'b0; mem_write = 1'b0;
    launch_address = '0; mem_address = '0; mem_data = '0; mem_byte_en = '0;
    tick();
    tick();
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass_to", 64'({pass, timed_out, scan}), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    check("rst_addr", 64'(core_program_address), 64'd0);
    reset = 1'b0;

    // Launch latency; mailbox writes before RUN must be ignored.
    launch = 1'b1;
    launch_address = 32'h100;
    tick();
    launch = 1'b0;
    launch_address = 32'hDEAD;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("lat%0d_core_reset", k), 64'(core_reset), 64'(k <= 4));
      check($sformatf("lat%0d_core_start", k), 64'(core_start), 64'(k == 5));
      check($sformatf("lat%0d_busy", k), 64'(busy), 64'd1);
      mem_write = 1'b1; mem_address = Tohost; mem_byte_en = 4'hF; mem_data = 32'h1;
      tick();
      mem_write = 1'b0;
    end
    check("lat_run_done", 64'(done), 64'd0);
    check("lat_run_core_reset", 64'(core_reset), 64'd0);
    check("lat_run_count", 64'(cycle_count), 64'd0);
    check("lat_addr", 64'(core_program_address), 64'h100);

    // Table of mailbox-terminated runs on the default instance.
    for (int i = 0; i < 5; i++) begin
      pulse_reset();
      launch_run(vecs[i].addr);
      run_until_done(1'b0, vecs[i].hit_cyc, vecs[i].data, 4'hF, 80, 1'b1, got, at);
      check($sformatf("v%0d_got", i), 64'(got), 64'd1);
      check($sformatf("v%0d_at", i), 64'(at), 64'(vecs[i].hit_cyc));
      check($sformatf("v%0d_pass", i), 64'(pass), 64'(vecs[i].exp_pass));
      check($sformatf("v%0d_timed_out", i), 64'(timed_out), 64'd0);
      check($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].data));
      check($sformatf("v%0d_count", i), 64'(cycle_count), 64'(vecs[i].hit_cyc));
      check($sformatf("v%0d_addr", i), 64'(core_program_address), 64'(vecs[i].addr));
      check($sformatf("v%0d_done_state", i), 64'({core_reset, busy}), 64'b10);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check($sformatf("v%0d_ack", i), 64'({done, busy}), 64'd0);
    end

    // Timeout on the 20-cycle instance, then a hit on the limit cycle.
    pulse_reset();
    launch_run(32'h0);
    run_until_done(1'b1, -1, 32'h0, 4'hF, 40, 1'b0, got, at);
    check("to_got", 64'(got), 64'd1);
    check("to_at", 64'(at), 64'd19);
    check("to_timed_out", 64'(t_timed_out), 64'd1);
    check("to_pass", 64'(t_pass), 64'd0);
    check("to_count", 64'(t_cycle_count), 64'd19);
    pulse_reset();
    launch_run(32'h0);
    run_until_done(1'b1, 19, 32'h1, 4'hF, 40, 1'b0, got, at);
    check("tohit_at", 64'(at), 64'd19);
    check("tohit_timed_out", 64'(t_timed_out), 64'd0);
    check("tohit_pass", 64'(t_pass), 64'd1);
    check("tohit_count", 64'(t_cycle_count), 64'd19);

    // Partial write, wrong address, launch and ack during RUN are all ignored.
    pulse_reset();
    launch_run(32'h600);
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) begin
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_done", 64'(done), 64'd0);
        check("ign_addr", 64'(core_program_address), 64'h600);
      end else begin
        mem_address = Tohost; mem_data = 32'h1; mem_byte_en = 4'hF;
        mem_write = (c == 5) || (c == 6);
        if (c == 5) mem_byte_en = 4'b0011;
        if (c == 6) mem_address = Tohost + 32'd4;
        launch = (c == 8);
        launch_address = 32'hBAD;
        ack = (c == 9);
        tick();
        mem_write = 1'b0; launch = 1'b0; ack = 1'b0;
      end
    end
    run_until_done(1'b0, 3, 32'h1, 4'hF, 20, 1'b0, got, at);
    check("ign_end_got", 64'(got), 64'd1);
    check("ign_end_count", 64'(cycle_count), 64'd15);
    check("ign_end_pass", 64'(pass), 64'd1);

    // Abort on RUN cycle 10 together with a mailbox hit.
    pulse_reset();
    launch_run(32'h700);
    for (int c = 0; c < 10; c++) tick();
    check("ab_count", 64'(cycle_count), 64'd10);
    abort = 1'b1;
    mem_write = 1'b1; mem_address = Tohost; mem_byte_en = 4'hF; mem_data = 32'h1;
    tick();
    abort = 1'b0;
    mem_write = 1'b0;
    check("ab_state", 64'({core_reset, busy, done}), 64'b100);
    tick(); tick(); tick();
    check("ab_no_done", 64'(done), 64'd0);
    launch_run(32'h710);
    run_until_done(1'b0, 4, 32'h1, 4'hF, 20, 1'b1, got, at);
    check("ab_relaunch_pass", 64'(pass), 64'd1);
    check("ab_relaunch_count", 64'(cycle_count), 64'd4);
    check("ab_relaunch_addr", 64'(core_program_address), 64'h710);

    // abort in DONE ignored; launch with ack returns to IDLE without relaunching.
    pulse_reset();
    launch_run(32'hA00);
    run_until_done(1'b0, 2, 32'h9, 4'hF, 20, 1'b0, got, at);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("dn_abort_done", 64'(done), 64'd1);
    check("dn_abort_result", 64'(result), 64'h9);
    launch = 1'b1; ack = 1'b1; launch_address = 32'hB00;
    tick();
    launch = 1'b0; ack = 1'b0;
    check("dn_ack", 64'({done, busy}), 64'd0);
    tick();
    check("dn_no_relaunch", 64'(busy), 64'd0);
    check("dn_addr", 64'(core_program_address), 64'hA00);

    // Synchronous reset in the middle of RUN.
    launch_run(32'hC00);
    for (int c = 0; c < 5; c++) tick();
    check("mr_count_pre", 64'(cycle_count), 64'd5);
    pulse_reset();
    check("mr_ctrl", 64'({core_reset, core_start, busy, done}), 64'b1000);
    check("mr_addr", 64'(core_program_address), 64'd0);
    check("mr_count", 64'(cycle_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
